// File: rtl/gumnut_bus_pkg.sv
// Shared Gumnut data-bus definitions: bus widths and the responder state type.
// Also used by the control unit for its bus port widths.
package gumnut_bus_pkg;

    localparam int unsigned GUMNUT_ADR_W = 8;
    localparam int unsigned GUMNUT_DAT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } resp_state_t;

    // Wait-state counter width; never narrower than one bit.
    function automatic int unsigned resp_cnt_width(input int unsigned wait_states);
        int unsigned w;
        w = $clog2(wait_states + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gumnut_dmem_array.sv
// Single-port DEPTHx8 synchronous data RAM with a registered, enable-gated read port.
// The array itself is not reset; only the read register is.
module gumnut_dmem_array
    import gumnut_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_i,
    input  logic                    re_i,
    input  logic [AW-1:0]           adr_i,
    input  logic [GUMNUT_DAT_W-1:0] wdat_i,
    output logic [GUMNUT_DAT_W-1:0] rdat_o
);

    logic [GUMNUT_DAT_W-1:0] mem_q [DEPTH];
    logic [GUMNUT_DAT_W-1:0] rdat_q;
    logic [GUMNUT_DAT_W-1:0] rdat_d;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[adr_i] <= wdat_i;
        end
    end

    // Read register holds its value until the next enabled read.
    always_comb begin
        rdat_d = rdat_q;
        if (re_i) begin
            rdat_d = mem_q[adr_i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdat_q <= '0;
        end else begin
            rdat_q <= rdat_d;
        end
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/gumnut_data_responder.sv
// Wishbone-classic responder for the Gumnut data bus with programmable wait states.
// Optional bounds checking via GUMNUT_DATA_RESP_BOUNDS_EN (data_err_o instead of ack).
module gumnut_data_responder
    import gumnut_bus_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned DEPTH       = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_cyc_i,
    input  logic                    data_stb_i,
    input  logic                    data_we_i,
    input  logic [GUMNUT_ADR_W-1:0] data_adr_i,
    input  logic [GUMNUT_DAT_W-1:0] data_dat_i,
    output logic [GUMNUT_DAT_W-1:0] data_dat_o,
    output logic                    data_ack_o,
    output logic                    data_err_o
);

    localparam int unsigned CntW = resp_cnt_width(WAIT_STATES);
    localparam int unsigned AW   = $clog2(DEPTH);

    resp_state_t             state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [GUMNUT_ADR_W-1:0] adr_q, adr_d;
    logic                    we_q, we_d;
    logic [GUMNUT_DAT_W-1:0] dat_q, dat_d;
    logic                    ack_q, ack_d;
    logic                    enter_ack;
    logic                    oob;
    logic                    mem_we;
    logic                    mem_re;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        we_d    = we_q;
        dat_d   = dat_q;
        unique case (state_q)
            IDLE: begin
                if (data_cyc_i && data_stb_i) begin
                    adr_d   = data_adr_i;
                    we_d    = data_we_i;
                    dat_d   = data_dat_i;
                    cnt_d   = CntW'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                if (!data_cyc_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (cnt_q != '0) ? cnt_q - CntW'(1) : '0;
                    if (cnt_q <= CntW'(1)) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // In IDLE with zero wait states the request goes straight to ACK, so the memory
    // must see the incoming fields; adr_d/we_d/dat_d already select them in that case.
    assign enter_ack = (state_d == ACK);

`ifdef GUMNUT_DATA_RESP_BOUNDS_EN
    logic err_q, err_d;

    assign oob   = ({1'b0, adr_d} >= (GUMNUT_ADR_W + 1)'(DEPTH));
    assign err_d = enter_ack & oob;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign data_err_o = err_q;
`else
    assign oob        = 1'b0;
    assign data_err_o = 1'b0;
`endif

    assign ack_d  = enter_ack & ~oob;
    assign mem_we = enter_ack & we_d & ~oob;
    assign mem_re = enter_ack & ~we_d & ~oob;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
        end
    end

    assign data_ack_o = ack_q;

    gumnut_dmem_array #(
        .DEPTH (DEPTH)
    ) u_dmem (
        .clk    (clk),
        .rst    (rst),
        .we_i   (mem_we),
        .re_i   (mem_re),
        .adr_i  (adr_d[AW-1:0]),
        .wdat_i (dat_d),
        .rdat_o (data_dat_o)
    );

endmodule

// File: tb/tb_gumnut_data_responder.sv
// Bench for gumnut_data_responder: two instances (WAIT_STATES=1/DEPTH=128 and
// WAIT_STATES=0/DEPTH=256) checked every cycle against a transaction-level schedule.
module tb_gumnut_data_responder;

    localparam int NCYC = 4096;
    int ws_of  [2] = '{1, 0};
    int dep_of [2] = '{128, 256};

    logic       clk = 1'b0;
    logic       rst  [2];
    logic       cyc  [2];
    logic       stb  [2];
    logic       we   [2];
    logic [7:0] adr  [2];
    logic [7:0] wdat [2];
    logic [7:0] rdat [2];
    logic       ack  [2];
    logic       err  [2];

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    bit         sched_ack [2][NCYC];
    bit         sched_err [2][NCYC];
    bit         sched_rv  [2][NCYC];
    logic [7:0] sched_dat [2][NCYC];
    logic [7:0] exp_dat   [2];
    logic [7:0] mem_m     [2][256];

    always #5 clk = ~clk;

    gumnut_data_responder #(
        .WAIT_STATES (1),
        .DEPTH       (128)
    ) u_dut_a (
        .clk        (clk),
        .rst        (rst[0]),
        .data_cyc_i (cyc[0]),
        .data_stb_i (stb[0]),
        .data_we_i  (we[0]),
        .data_adr_i (adr[0]),
        .data_dat_i (wdat[0]),
        .data_dat_o (rdat[0]),
        .data_ack_o (ack[0]),
        .data_err_o (err[0])
    );

    gumnut_data_responder #(
        .WAIT_STATES (0),
        .DEPTH       (256)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst[1]),
        .data_cyc_i (cyc[1]),
        .data_stb_i (stb[1]),
        .data_we_i  (we[1]),
        .data_adr_i (adr[1]),
        .data_dat_i (wdat[1]),
        .data_dat_o (rdat[1]),
        .data_ack_o (ack[1]),
        .data_err_o (err[1])
    );

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Per-cycle comparison of every output of both instances against the schedule.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic ea, ee;
            ea = 1'b0;
            ee = 1'b0;
            if (rst[i]) begin
                exp_dat[i] = 8'h00;
            end else if (cyc_n < NCYC) begin
                ea = sched_ack[i][cyc_n];
                ee = sched_err[i][cyc_n];
                if (sched_rv[i][cyc_n]) exp_dat[i] = sched_dat[i][cyc_n];
            end
            check8($sformatf("cyc_ack[%0d]", i), {7'd0, ack[i]}, {7'd0, ea});
            check8($sformatf("cyc_err[%0d]", i), {7'd0, err[i]}, {7'd0, ee});
            check8($sformatf("cyc_dat[%0d]", i), rdat[i], exp_dat[i]);
        end
    end

    // One complete transfer; returns #1 into the cycle where ack/err is expected.
    task automatic xfer(input int i, input bit w, input logic [7:0] a, input logic [7:0] d);
        int  c, rc, idx;
        bit  oob;
        @(posedge clk);
        #1;
        cyc[i]  = 1'b1;
        stb[i]  = 1'b1;
        we[i]   = w;
        adr[i]  = a;
        wdat[i] = d;
        c   = cyc_n;
        rc  = c + 1 + ws_of[i];
        idx = int'(a) % dep_of[i];
`ifdef GUMNUT_DATA_RESP_BOUNDS_EN
        oob = (int'(a) >= dep_of[i]);
`else
        oob = 1'b0;
`endif
        if (oob) begin
            sched_err[i][rc] = 1'b1;
        end else begin
            sched_ack[i][rc] = 1'b1;
            if (w) begin
                mem_m[i][idx] = d;
            end else begin
                sched_rv[i][rc]  = 1'b1;
                sched_dat[i][rc] = mem_m[i][idx];
            end
        end
        @(posedge clk);
        #1;
        stb[i] = 1'b0;
        repeat (ws_of[i]) begin
            @(posedge clk);
            #1;
        end
        cyc[i] = 1'b0;
    endtask

    initial begin
        int c;
        for (int i = 0; i < 2; i++) begin
            rst[i]     = 1'b1;
            cyc[i]     = 1'b0;
            stb[i]     = 1'b0;
            we[i]      = 1'b0;
            adr[i]     = 8'h00;
            wdat[i]    = 8'h00;
            exp_dat[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        check8("reset_dat_a", rdat[0], 8'h00);
        check8("reset_ack_a", {7'd0, ack[0]}, 8'h00);
        check8("reset_err_a", {7'd0, err[0]}, 8'h00);
        check8("reset_dat_b", rdat[1], 8'h00);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Write then read, one wait state.
        xfer(0, 1'b1, 8'h3C, 8'hA5);
        check8("ws1_write_ack", {7'd0, ack[0]}, 8'h01);
        xfer(0, 1'b0, 8'h3C, 8'h00);
        check8("ws1_read_ack", {7'd0, ack[0]}, 8'h01);
        check8("ws1_read_dat", rdat[0], 8'hA5);

        // Zero wait states: preload, then back-to-back reads with stb held.
        xfer(1, 1'b1, 8'h00, 8'h11);
        xfer(1, 1'b1, 8'h01, 8'h22);
        @(posedge clk);
        #1;
        cyc[1] = 1'b1;
        stb[1] = 1'b1;
        we[1]  = 1'b0;
        adr[1] = 8'h00;
        c = cyc_n;
        sched_ack[1][c+1] = 1'b1;
        sched_rv[1][c+1]  = 1'b1;
        sched_dat[1][c+1] = mem_m[1][0];
        sched_ack[1][c+3] = 1'b1;
        sched_rv[1][c+3]  = 1'b1;
        sched_dat[1][c+3] = mem_m[1][1];
        @(posedge clk);
        #1;
        check8("b2b_ack1", {7'd0, ack[1]}, 8'h01);
        check8("b2b_dat1", rdat[1], 8'h11);
        adr[1] = 8'h01;
        @(posedge clk);
        #1;
        check8("b2b_gap", {7'd0, ack[1]}, 8'h00);
        @(posedge clk);
        #1;
        check8("b2b_ack2", {7'd0, ack[1]}, 8'h01);
        check8("b2b_dat2", rdat[1], 8'h22);
        stb[1] = 1'b0;
        cyc[1] = 1'b0;

        // Abort: cyc drops in the WAIT cycle of a write.
        xfer(0, 1'b1, 8'h10, 8'h00);
        @(posedge clk);
        #1;
        cyc[0] = 1'b1;
        stb[0] = 1'b1;
        we[0]  = 1'b1;
        adr[0] = 8'h10;
        wdat[0] = 8'hFF;
        @(posedge clk);
        #1;
        cyc[0] = 1'b0;
        stb[0] = 1'b0;
        @(posedge clk);
        #1;
        check8("abort_no_ack", {7'd0, ack[0]}, 8'h00);
        xfer(0, 1'b0, 8'h10, 8'h00);
        check8("abort_old_val", rdat[0], 8'h00);

        // Reset during WAIT discards the pending write.
        xfer(0, 1'b1, 8'h20, 8'h33);
        xfer(0, 1'b0, 8'h3C, 8'h00);
        check8("pre_reset_dat", rdat[0], 8'hA5);
        @(posedge clk);
        #1;
        cyc[0] = 1'b1;
        stb[0] = 1'b1;
        we[0]  = 1'b1;
        adr[0] = 8'h20;
        wdat[0] = 8'h77;
        @(posedge clk);
        #1;
        stb[0] = 1'b0;
        #1;
        rst[0] = 1'b1;
        #1;
        check8("rst_async_ack", {7'd0, ack[0]}, 8'h00);
        check8("rst_async_dat", rdat[0], 8'h00);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        cyc[0] = 1'b0;
        xfer(0, 1'b0, 8'h20, 8'h00);
        check8("rst_write_lost", rdat[0], 8'h33);

        // Out-of-range address on the DEPTH=128 instance.
        xfer(0, 1'b1, 8'h90, 8'h5A);
`ifdef GUMNUT_DATA_RESP_BOUNDS_EN
        check8("oob_err", {7'd0, err[0]}, 8'h01);
        check8("oob_no_ack", {7'd0, ack[0]}, 8'h00);
        xfer(0, 1'b0, 8'h10, 8'h00);
        check8("oob_unchanged", rdat[0], 8'h00);
`else
        check8("alias_ack", {7'd0, ack[0]}, 8'h01);
        check8("alias_no_err", {7'd0, err[0]}, 8'h00);
        xfer(0, 1'b0, 8'h10, 8'h00);
        check8("alias_read", rdat[0], 8'h5A);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
